reg_trace_checker: RTL and testbench
====================================

// Module: reg_trace_checker
// PURPOSE
//  Synthesizable, parametrised register-trace checker for the CPU core.
//  Holds a vector RAM of {opcode, expected register file} entries. Steps one entry per accepted
//  opcode fetch and compares live register state at each instruction retire.
//  Counts vectors and errors; stops on a STOP opcode fetch.
//  Sits beside top, fed by decoder fetch/hold/retire strobes and the register-file outputs.
// PARAMETERS
//  NUM_REGS  8        registers compared, packed MSB-first (A,B,C,D,E,H,L,F)
//  REG_W     8        width of each register
//  OP_W      8        opcode width stored per vector
//  ADDR_W    16       vector RAM address width; depth = 1<<ADDR_W
//  STOP_OP   8'h10    opcode that terminates a run
//  CMP_MASK  8'hFE    per-register compare enable, bit i = register i (default excludes F)
// PORTS
//  clk         in   1                    system clock, rising edge
//  rst         in   1                    asynchronous reset, active-low
//  vec_we      in   1                    vector RAM write strobe (honoured in IDLE/DONE only)
//  vec_waddr   in   ADDR_W               vector RAM write address
//  vec_wdata   in   OP_W+NUM_REGS*REG_W  {opcode, expected regs}
//  vec_num     in   ADDR_W+1             number of valid vectors loaded
//  start       in   1                    arm checker (IDLE/DONE only)
//  fetch_stb   in   1                    opcode fetch cycle (M1 T1)
//  fetch_op    in   OP_W                 opcode on data bus at fetch_stb
//  hold        in   1                    decoder hold; fetch_stb ignored while high
//  retire_stb  in   1                    last T-cycle of last M-cycle of an instruction
//  regs        in   NUM_REGS*REG_W       live register file
//  busy        out  1                    ARMED or RUN
//  done        out  1                    run finished (sticky until start/reset)
//  pass        out  1                    done & err_count==0 & vec_count!=0
//  overrun     out  1                    fetch accepted with pointer >= vec_num (sticky)
//  vec_count   out  32                   vectors compared
//  err_count   out  32                   compares with any masked mismatch
//  mismatch    out  NUM_REGS             per-register mismatch of most recent compare
//  cmp_valid   out  1                    1-cycle pulse: compare performed this cycle
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; ptr, cur/next valid bits 0. RAM contents not reset.
//  - FSM: IDLE -start-> ARMED; ARMED -(fetch_stb & ~hold & fetch_op!=STOP_OP)-> RUN
//    (this fetch is accepted). RUN -(fetch_stb & ~hold & fetch_op==STOP_OP)-> DONE. DONE -start-> ARMED.
//  - start clears ptr, counters, overrun, mismatch, done, valid bits. start ignored in ARMED/RUN.
//  - Accepted fetch: cur <= next (incl. valid); RAM read issued at ptr; ptr <= ptr+1.
//  - RAM: synchronous read, 1-cycle latency.
//    next <= RAM[ptr], next.valid <= (ptr < vec_num). Otherwise overrun <= 1, next.valid <= 0.
//  - ptr saturates at (1<<ADDR_W); no wrap.
//  - Compare: retire_stb in RUN with cur.valid.
//    mismatch[i] <= (regs_i != exp_i) & CMP_MASK[i].
//    vec_count++; err_count++ if |mismatch; cmp_valid pulses the same cycle the registers update.
//  - Pipelining: the compare checks the instruction fetched one accept earlier.
//  - retire_stb and fetch_stb in the same cycle: the compare uses the pre-update cur.
//  - retire_stb with cur.valid==0: no compare, no count.
//  - STOP fetch in RUN: pending cur is not compared; the stopping fetch does not advance ptr.
//  - Counters saturate at 32'hFFFF_FFFF.
//  - vec_we in ARMED/RUN is dropped.
//  - rst low mid-run: immediate return to IDLE, outputs cleared.
// CONFIGURATION
//  REG_TRACE_CAPTURE_EN defined:
//    adds outputs first_err_idx[ADDR_W] and first_err_regs[NUM_REGS*REG_W].
//    Loaded with the vector index and live regs at the first erroring compare after start.
//    Held until start or reset; 0 when no error.
//  REG_TRACE_CAPTURE_EN undefined: these ports and their registers do not exist;
//    all other behaviour is identical.
// TESTING
//  1 Load 3 vectors; vec_num=3.
//    Ops 3E,06,0E then 10, regs matching -> done=1, pass=1, vec_count=2, err_count=0.
//  2 Same run, B off by 8'h01 at second compare -> err_count=1, mismatch=8'b0100_0000, pass=0.
//  3 F wrong only, CMP_MASK=8'hFE -> no error.
//    Same with CMP_MASK=8'hFF -> err_count=1, mismatch[0]=1.
//  4 hold=1 during 2 fetch_stb pulses -> ptr unchanged; then hold=0 -> ptr advances by 1 per fetch.
//  5 vec_num=1, 3 accepted fetches -> overrun=1; retires with invalid cur not counted (vec_count<=1).
//  6 rst low mid-RUN after 2 compares -> all outputs 0 next edge.
//    start, rerun -> counters restart from 0.
//    With REG_TRACE_CAPTURE_EN, first_err_idx matches the first failing index.

Source files
------------

// File: rtl/reg_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : reg_trace_checker
// Description : Register-trace checker for the CPU core. A vector RAM holds
//               {opcode, expected register file} entries. Each accepted
//               opcode fetch steps the vector pointer; each instruction retire
//               compares the live register file against the vector fetched one
//               accept earlier. Vectors compared and compares with errors are
//               counted; a STOP opcode fetch ends the run.
// Ports       : clk, rst_n                  clock, async active-low reset
//               vec_we_i/vec_waddr_i/vec_wdata_i  vector RAM write (IDLE/DONE)
//               vec_num_i                   number of valid vectors
//               start_i                     arm checker (IDLE/DONE)
//               fetch_stb_i/fetch_op_i/hold_i     decoder fetch strobe/opcode/hold
//               retire_stb_i/regs_i         instruction retire, live registers
//               busy_o/done_o/pass_o/overrun_o    status
//               vec_count_o/err_count_o     saturating counters
//               mismatch_o/cmp_valid_o      last compare result / compare pulse
// Option      : `define REG_TRACE_CAPTURE_EN adds first_err_idx_o and
//               first_err_regs_o (index and live regs of first failing compare).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_trace_checker #(
    parameter int                  NUM_REGS = 8,
    parameter int                  REG_W    = 8,
    parameter int                  OP_W     = 8,
    parameter int                  ADDR_W   = 16,
    parameter logic [OP_W-1:0]     STOP_OP  = 8'h10,
    parameter logic [NUM_REGS-1:0] CMP_MASK = 8'hFE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vec_we_i,
    input  logic [ADDR_W-1:0]              vec_waddr_i,
    input  logic [OP_W+NUM_REGS*REG_W-1:0] vec_wdata_i,
    input  logic [ADDR_W:0]                vec_num_i,
    input  logic                           start_i,
    input  logic                           fetch_stb_i,
    input  logic [OP_W-1:0]                fetch_op_i,
    input  logic                           hold_i,
    input  logic                           retire_stb_i,
    input  logic [NUM_REGS*REG_W-1:0]      regs_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           overrun_o,
    output logic [31:0]                    vec_count_o,
    output logic [31:0]                    err_count_o,
    output logic [NUM_REGS-1:0]            mismatch_o,
    output logic                           cmp_valid_o
`ifdef REG_TRACE_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]              first_err_idx_o,
    output logic [NUM_REGS*REG_W-1:0]      first_err_regs_o
`endif
);

    localparam int              RW      = NUM_REGS * REG_W;
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic [RW-1:0]       cur_data_q, cur_data_d;
    logic                cur_vld_q, cur_vld_d;
    logic [RW-1:0]       nxt_data_q;
    logic                nxt_vld_q, nxt_vld_d;
    logic                overrun_q, overrun_d;
    logic [31:0]         vec_cnt_q, vec_cnt_d;
    logic [31:0]         err_cnt_q, err_cnt_d;
    logic [NUM_REGS-1:0] mis_q, mis_d;
    logic                cmp_q, cmp_d;

    logic [RW-1:0]       mem_q [DEPTH];

    logic                w_idle_or_done;
    logic                w_start;
    logic                w_fetch;
    logic                w_stop;
    logic                w_accept;
    logic                w_cmp;
    logic [NUM_REGS-1:0] w_mis;

    // The stored opcode is kept in the vector format for trace readability
    // but the checker only compares register state.
    logic                w_unused_op;
    assign w_unused_op = ^vec_wdata_i[OP_W+RW-1:RW];

`ifdef REG_TRACE_CAPTURE_EN
    logic [ADDR_W-1:0]   nxt_idx_q, nxt_idx_d;
    logic [ADDR_W-1:0]   cur_idx_q, cur_idx_d;
    logic [ADDR_W-1:0]   fe_idx_q, fe_idx_d;
    logic [RW-1:0]       fe_regs_q, fe_regs_d;
`endif

    assign w_idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_start        = start_i & w_idle_or_done;
    assign w_fetch        = fetch_stb_i & ~hold_i & ((state_q == S_ARMED) || (state_q == S_RUN));
    assign w_stop         = w_fetch & (fetch_op_i == STOP_OP);
    assign w_accept       = w_fetch & ~w_stop;
    assign w_cmp          = retire_stb_i & (state_q == S_RUN) & cur_vld_q;

    always_comb begin
        w_mis = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_mis[i] = (regs_i[i*REG_W +: REG_W] != cur_data_q[i*REG_W +: REG_W]) & CMP_MASK[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_data_d = cur_data_q;
        cur_vld_d  = cur_vld_q;
        nxt_vld_d  = nxt_vld_q;
        overrun_d  = overrun_q;
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        mis_d      = mis_q;
        cmp_d      = 1'b0;
`ifdef REG_TRACE_CAPTURE_EN
        nxt_idx_d  = nxt_idx_q;
        cur_idx_d  = cur_idx_q;
        fe_idx_d   = fe_idx_q;
        fe_regs_d  = fe_regs_q;
`endif
        if (w_start) begin
            state_d   = S_ARMED;
            ptr_d     = '0;
            cur_vld_d = 1'b0;
            nxt_vld_d = 1'b0;
            overrun_d = 1'b0;
            vec_cnt_d = '0;
            err_cnt_d = '0;
            mis_d     = '0;
`ifdef REG_TRACE_CAPTURE_EN
            fe_idx_d  = '0;
            fe_regs_d = '0;
`endif
        end else begin
            // Compare sees cur as it was before any same-cycle fetch update.
            if (w_cmp) begin
                cmp_d = 1'b1;
                mis_d = w_mis;
                if (vec_cnt_q != CNT_MAX) begin
                    vec_cnt_d = vec_cnt_q + 32'd1;
                end
                if (|w_mis) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                    end
`ifdef REG_TRACE_CAPTURE_EN
                    if (err_cnt_q == '0) begin
                        fe_idx_d  = cur_idx_q;
                        fe_regs_d = regs_i;
                    end
`endif
                end
            end
            if (w_accept) begin
                state_d    = S_RUN;
                cur_data_d = nxt_data_q;
                cur_vld_d  = nxt_vld_q;
                nxt_vld_d  = (ptr_q < vec_num_i);
                if (ptr_q >= vec_num_i) begin
                    overrun_d = 1'b1;
                end
                if (ptr_q != PTR_MAX) begin
                    ptr_d = ptr_q + PTR_ONE;
                end
`ifdef REG_TRACE_CAPTURE_EN
                cur_idx_d = nxt_idx_q;
                nxt_idx_d = ptr_q[ADDR_W-1:0];
`endif
            end else if (w_stop && (state_q == S_RUN)) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cur_data_q <= '0;
            cur_vld_q  <= 1'b0;
            nxt_vld_q  <= 1'b0;
            overrun_q  <= 1'b0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            mis_q      <= '0;
            cmp_q      <= 1'b0;
`ifdef REG_TRACE_CAPTURE_EN
            nxt_idx_q  <= '0;
            cur_idx_q  <= '0;
            fe_idx_q   <= '0;
            fe_regs_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_data_q <= cur_data_d;
            cur_vld_q  <= cur_vld_d;
            nxt_vld_q  <= nxt_vld_d;
            overrun_q  <= overrun_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            mis_q      <= mis_d;
            cmp_q      <= cmp_d;
`ifdef REG_TRACE_CAPTURE_EN
            nxt_idx_q  <= nxt_idx_d;
            cur_idx_q  <= cur_idx_d;
            fe_idx_q   <= fe_idx_d;
            fe_regs_q  <= fe_regs_d;
`endif
        end
    end

    // Vector RAM: writes only while no run is in progress, synchronous read
    // into the "next" slot on every accepted fetch.
    always_ff @(posedge clk) begin
        if (vec_we_i && w_idle_or_done) begin
            mem_q[vec_waddr_i] <= vec_wdata_i[RW-1:0];
        end
        if (w_accept) begin
            nxt_data_q <= mem_q[ptr_q[ADDR_W-1:0]];
        end
    end

    assign busy_o      = (state_q == S_ARMED) || (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = done_o && (err_cnt_q == '0) && (vec_cnt_q != '0);
    assign overrun_o   = overrun_q;
    assign vec_count_o = vec_cnt_q;
    assign err_count_o = err_cnt_q;
    assign mismatch_o  = mis_q;
    assign cmp_valid_o = cmp_q;
`ifdef REG_TRACE_CAPTURE_EN
    assign first_err_idx_o  = fe_idx_q;
    assign first_err_regs_o = fe_regs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_trace_checker
// Description : Self-checking bench for reg_trace_checker. Two instances share
//               all inputs: u_a uses the default compare mask (F excluded),
//               u_b compares all registers. A behavioural model tracks the
//               number of accepted fetches since start; the vector compared at
//               a retire is the one at index (accepts - 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_trace_checker;

    localparam int ST_IDLE = 0, ST_ARMED = 1, ST_RUN = 2, ST_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vec_we = 1'b0;
    logic [15:0] vec_waddr = '0;
    logic [71:0] vec_wdata = '0;
    logic [16:0] vec_num = '0;
    logic        start = 1'b0;
    logic        fetch_stb = 1'b0;
    logic [7:0]  fetch_op = '0;
    logic        hold = 1'b0;
    logic        retire_stb = 1'b0;
    logic [63:0] regs = '0;

    logic        a_busy, a_done, a_pass, a_over, a_cmpv;
    logic [31:0] a_vec, a_err;
    logic [7:0]  a_mis;
    logic        b_busy, b_done, b_pass, b_over, b_cmpv;
    logic [31:0] b_vec, b_err;
    logic [7:0]  b_mis;
`ifdef REG_TRACE_CAPTURE_EN
    logic [15:0] a_fidx, b_fidx;
    logic [63:0] a_fregs, b_fregs;
`endif

    always #5 clk = ~clk;

    reg_trace_checker #(.CMP_MASK(8'hFE)) u_a (
        .clk(clk), .rst_n(rst_n), .vec_we_i(vec_we), .vec_waddr_i(vec_waddr),
        .vec_wdata_i(vec_wdata), .vec_num_i(vec_num), .start_i(start),
        .fetch_stb_i(fetch_stb), .fetch_op_i(fetch_op), .hold_i(hold),
        .retire_stb_i(retire_stb), .regs_i(regs), .busy_o(a_busy), .done_o(a_done),
        .pass_o(a_pass), .overrun_o(a_over), .vec_count_o(a_vec), .err_count_o(a_err),
        .mismatch_o(a_mis), .cmp_valid_o(a_cmpv)
`ifdef REG_TRACE_CAPTURE_EN
        , .first_err_idx_o(a_fidx), .first_err_regs_o(a_fregs)
`endif
    );

    reg_trace_checker #(.CMP_MASK(8'hFF)) u_b (
        .clk(clk), .rst_n(rst_n), .vec_we_i(vec_we), .vec_waddr_i(vec_waddr),
        .vec_wdata_i(vec_wdata), .vec_num_i(vec_num), .start_i(start),
        .fetch_stb_i(fetch_stb), .fetch_op_i(fetch_op), .hold_i(hold),
        .retire_stb_i(retire_stb), .regs_i(regs), .busy_o(b_busy), .done_o(b_done),
        .pass_o(b_pass), .overrun_o(b_over), .vec_count_o(b_vec), .err_count_o(b_err),
        .mismatch_o(b_mis), .cmp_valid_o(b_cmpv)
`ifdef REG_TRACE_CAPTURE_EN
        , .first_err_idx_o(b_fidx), .first_err_regs_o(b_fregs)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    logic [63:0] m_mem [0:63];
    int          m_state = ST_IDLE;
    int          m_k = 0;
    logic [31:0] m_vec = '0, m_err_a = '0, m_err_b = '0;
    logic [7:0]  m_mis_a = '0, m_mis_b = '0;
    bit          m_over = 1'b0, m_cmp = 1'b0;
    int          m_fidx_a = 0, m_fidx_b = 0;
    logic [63:0] m_fregs_a = '0, m_fregs_b = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mis_of(input logic [63:0] live, input logic [63:0] exp,
                                          input logic [7:0] mask);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (live[i*8 +: 8] != exp[i*8 +: 8]) && mask[i];
        return m;
    endfunction

    function automatic bit cur_valid();
        return (m_k >= 2) && ((m_k - 2) < int'(vec_num));
    endfunction

    function automatic logic [63:0] cur_exp();
        return cur_valid() ? m_mem[m_k - 2] : {$urandom(), $urandom()};
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        m_cmp = 1'b0;
        if (!rst_n) begin
            m_state = ST_IDLE; m_k = 0; m_vec = '0; m_err_a = '0; m_err_b = '0;
            m_mis_a = '0; m_mis_b = '0; m_over = 1'b0;
            m_fidx_a = 0; m_fidx_b = 0; m_fregs_a = '0; m_fregs_b = '0;
            return;
        end
        if (vec_we && (m_state == ST_IDLE || m_state == ST_DONE) && vec_waddr < 16'd64)
            m_mem[vec_waddr[5:0]] = vec_wdata[63:0];
        if (start && (m_state == ST_IDLE || m_state == ST_DONE)) begin
            m_state = ST_ARMED; m_k = 0; m_vec = '0; m_err_a = '0; m_err_b = '0;
            m_mis_a = '0; m_mis_b = '0; m_over = 1'b0;
            m_fidx_a = 0; m_fidx_b = 0; m_fregs_a = '0; m_fregs_b = '0;
            return;
        end
        if (m_state == ST_RUN && retire_stb && cur_valid()) begin
            m_cmp   = 1'b1;
            m_mis_a = mis_of(regs, m_mem[m_k - 2], 8'hFE);
            m_mis_b = mis_of(regs, m_mem[m_k - 2], 8'hFF);
            if (m_vec != 32'hFFFF_FFFF) m_vec++;
            if (m_mis_a != 0) begin
                if (m_err_a == 0) begin m_fidx_a = m_k - 2; m_fregs_a = regs; end
                m_err_a++;
            end
            if (m_mis_b != 0) begin
                if (m_err_b == 0) begin m_fidx_b = m_k - 2; m_fregs_b = regs; end
                m_err_b++;
            end
        end
        if (fetch_stb && !hold && (m_state == ST_ARMED || m_state == ST_RUN)) begin
            if (fetch_op == 8'h10) begin
                if (m_state == ST_RUN) m_state = ST_DONE;
            end else begin
                if (m_k >= int'(vec_num)) m_over = 1'b1;
                m_k++;
                m_state = ST_RUN;
            end
        end
    endtask

    task automatic check_all();
        bit busy_e, done_e;
        busy_e = (m_state == ST_ARMED) || (m_state == ST_RUN);
        done_e = (m_state == ST_DONE);
        chk("busy_a", a_busy, busy_e);
        chk("done_a", a_done, done_e);
        chk("pass_a", a_pass, done_e && m_err_a == 0 && m_vec != 0);
        chk("overrun_a", a_over, m_over);
        chk("vec_count_a", a_vec, m_vec);
        chk("err_count_a", a_err, m_err_a);
        chk("mismatch_a", a_mis, m_mis_a);
        chk("cmp_valid_a", a_cmpv, m_cmp);
        chk("pass_b", b_pass, done_e && m_err_b == 0 && m_vec != 0);
        chk("err_count_b", b_err, m_err_b);
        chk("mismatch_b", b_mis, m_mis_b);
        chk("vec_count_b", b_vec, m_vec);
`ifdef REG_TRACE_CAPTURE_EN
        chk("first_err_idx_a", a_fidx, 64'(m_fidx_a));
        chk("first_err_regs_a", a_fregs, m_fregs_a);
        chk("first_err_idx_b", b_fidx, 64'(m_fidx_b));
        chk("first_err_regs_b", b_fregs, m_fregs_b);
`endif
    endtask

    // One clock cycle with the given strobes; start/vec_we are set by caller.
    task automatic cyc(input bit f, input logic [7:0] op, input bit h, input bit r,
                       input logic [63:0] rg);
        fetch_stb = f; fetch_op = op; hold = h; retire_stb = r; regs = rg;
        model_step();
        @(posedge clk); #1;
        fetch_stb = 1'b0; retire_stb = 1'b0; start = 1'b0; vec_we = 1'b0; hold = 1'b0;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, {$urandom(), $urandom()});
    endtask

    task automatic load(input int addr, input logic [7:0] op);
        vec_we = 1'b1; vec_waddr = 16'(addr); vec_wdata = {op, $urandom(), $urandom()};
        idle();
    endtask

    task automatic fetch(input logic [7:0] op);
        cyc(1'b1, op, 1'b0, 1'b0, {$urandom(), $urandom()});
    endtask

    task automatic retire(input logic [63:0] flip);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, cur_exp() ^ flip);
    endtask

    // Ops 3E,06,0E with a retire after each, then STOP.
    task automatic basic_run(input logic [63:0] flip2);
        start = 1'b1; idle();
        fetch(8'h3E); retire('0);
        fetch(8'h06); retire('0);
        fetch(8'h0E); retire(flip2);
        fetch(8'h10); idle();
    endtask

    initial begin
        logic [63:0] flip;
        bit          f, h, r;
        logic [7:0]  op;

        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        rst_n = 1'b0;
        idle(); idle();
        chk("reset_vec_count", a_vec, 64'd0);
        rst_n = 1'b1;
        idle();

        // Three vectors, matching registers
        load(0, 8'h3E); load(1, 8'h06); load(2, 8'h0E);
        vec_num = 17'd3;
        basic_run('0);
        chk("t1_done", a_done, 64'd1);
        chk("t1_pass", a_pass, 64'd1);
        chk("t1_vec_count", a_vec, 64'd2);
        chk("t1_err_count", a_err, 64'd0);

        // B register wrong at second compare
        basic_run(64'h0001_0000_0000_0000);
        chk("t2_err_count", a_err, 64'd1);
        chk("t2_mismatch", a_mis, 64'h40);
        chk("t2_pass", a_pass, 64'd0);

        // F register wrong: masked on u_a, caught on u_b
        basic_run(64'h0000_0000_0000_0001);
        chk("t3_err_masked", a_err, 64'd0);
        chk("t3_err_unmasked", b_err, 64'd1);
        chk("t3_mis_unmasked", b_mis, 64'h01);

        // Held fetches must not advance the pointer: first compare uses vector 0
        start = 1'b1; idle();
        cyc(1'b1, 8'h3E, 1'b1, 1'b0, '0);
        cyc(1'b1, 8'h3E, 1'b1, 1'b0, '0);
        chk("t4_still_armed", a_busy, 64'd1);
        fetch(8'h3E); retire('0);
        fetch(8'h06); retire('0);
        chk("t4_vec_count", a_vec, 64'd1);
        chk("t4_err_count", b_err, 64'd0);
        fetch(8'h10); idle();

        // Overrun with a single valid vector
        vec_num = 17'd1;
        start = 1'b1; idle();
        for (int i = 0; i < 3; i++) begin fetch(8'h01); retire('0); end
        chk("t5_overrun", a_over, 64'd1);
        chk("t5_vec_count", a_vec, 64'd1);
        fetch(8'h10); idle();

        // Randomised run over 20 vectors
        for (int i = 0; i < 20; i++) load(i, 8'($urandom()));
        vec_num = 17'd20;
        start = 1'b1; idle();
        for (int n = 0; n < 150; n++) begin
            f  = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 1) == 0);
            op = 8'($urandom());
            if (op == 8'h10) op = 8'h11;
            flip = ($urandom_range(0, 3) == 0) ? (64'($urandom_range(1, 255)) << (8 * $urandom_range(0, 7))) : '0;
            if ($urandom_range(0, 15) == 0) start = 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                vec_we = 1'b1; vec_waddr = 16'($urandom_range(0, 19));
                vec_wdata = {8'h00, $urandom(), $urandom()};
            end
            cyc(f, op, h, r, cur_exp() ^ flip);
        end

        // Reset mid-run clears everything
        rst_n = 1'b0; idle();
        chk("t6_busy", a_busy, 64'd0);
        chk("t6_vec_count", a_vec, 64'd0);
        chk("t6_err_count", a_err, 64'd0);
        rst_n = 1'b1; idle();

        // Rerun: counters restart, first error index captured
        start = 1'b1; idle();
        fetch(8'h21); retire('0);
        fetch(8'h22); retire('0);
        fetch(8'h23); retire('0);
        fetch(8'h24); retire(64'h0000_0100_0000_0000);
        fetch(8'h25); retire(64'h0200_0000_0000_0000);
        chk("t6_rerun_vec_count", a_vec, 64'd4);
        chk("t6_rerun_err_count", a_err, 64'd2);
`ifdef REG_TRACE_CAPTURE_EN
        chk("t6_first_err_idx", a_fidx, 64'd2);
`endif
        fetch(8'h10); idle();
        chk("t6_done", a_done, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
